// File: rtl/reflet_mult_accumulator.sv
// reflet_mult_accumulator: sits behind reflet_slow_multiplication. It tags each operand
// pair issued to the multiplier and sums LENGTH products into a saturating dot product.
// The result is offered on a valid/ready port.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   enable         stall control shared with the multiplier (freezes everything except
//                  the result handshake)
//   start, length  begin a dot product of `length` terms (sampled only while idle)
//   operand_valid  operand pair presented to the multiplier this cycle
//   operand_ready  block accepts an operand pair this cycle
//   product        multiplier output
//   busy           block is not idle
//   out_valid,
//   out_ready,
//   out            result handshake and dot product
//   overflow       result saturated (qualified by out_valid)
module reflet_mult_accumulator #(
  parameter int unsigned WORD_SIZE    = 6,
  parameter int unsigned MULT_LATENCY = 6,
  parameter int unsigned COUNT_WIDTH  = 4,
  parameter int unsigned ACC_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] length,
  input  logic                   operand_valid,
  output logic                   operand_ready,
  input  logic [2*WORD_SIZE-1:0] product,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out,
  output logic                   overflow
);

  localparam int unsigned SUM_W = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [MULT_LATENCY-1:0] tag_q, tag_d;
  logic [COUNT_WIDTH-1:0]  len_q, len_d;
  logic [COUNT_WIDTH-1:0]  issued_q, issued_d;
  logic [COUNT_WIDTH-1:0]  received_q, received_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    acc_ovf_q, acc_ovf_d;
  logic [ACC_WIDTH-1:0]    out_q, out_d;
  logic                    ovf_q, ovf_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;

  logic                    accept_c;
  logic                    tag_exit_c;
  logic [SUM_W-1:0]        sum_c;
  logic [ACC_WIDTH-1:0]    acc_sat_c;

  // Issue acceptance, tag exit and saturating add of the arriving product.
  always_comb begin
    accept_c   = operand_valid && ready_q && enable;
    tag_exit_c = tag_q[MULT_LATENCY-1];
    sum_c      = SUM_W'(acc_q) + SUM_W'(product);
    acc_sat_c  = sum_c[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_c[ACC_WIDTH-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;
    acc_d      = acc_q;
    acc_ovf_d  = acc_ovf_q;
    out_d      = out_q;
    ovf_d      = ovf_q;

    if (enable) begin
      // Shift in the issue marker; a tag leaving the top bit lines up with its product.
      tag_d = MULT_LATENCY'({tag_q, accept_c});
      if (accept_c) begin
        issued_d = issued_q + COUNT_WIDTH'(1);
      end
      if (tag_exit_c && (state_q == S_ACCUM || state_q == S_DRAIN)) begin
        acc_d      = acc_sat_c;
        acc_ovf_d  = acc_ovf_q | sum_c[ACC_WIDTH];
        received_d = received_q + COUNT_WIDTH'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enable && start) begin
          len_d      = length;
          issued_d   = '0;
          received_d = '0;
          acc_d      = '0;
          acc_ovf_d  = 1'b0;
          if (length == '0) begin
            state_d = S_OUTPUT;
            out_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (enable && issued_d == len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // acc_d already includes a product landing this cycle.
        if (enable && received_d == len_q) begin
          state_d = S_OUTPUT;
          out_d   = acc_d;
          ovf_d   = acc_ovf_d;
        end
      end
      S_OUTPUT: begin
        // Handshake completes even while stalled.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_ACCUM) && (issued_d < len_d);
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_OUTPUT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      acc_q      <= acc_d;
      acc_ovf_q  <= acc_ovf_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign operand_ready = ready_q;
  assign busy          = busy_q;
  assign out_valid     = valid_q;
  assign out           = out_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_reflet_mult_accumulator.sv
// Bench for reflet_mult_accumulator: a 16-bit and a 15-bit accumulator share one
// multiplier model; expected results are queued by the driver and popped by a monitor.
module tb_reflet_mult_accumulator;

  localparam int unsigned WS  = 6;
  localparam int unsigned LAT = 6;
  localparam int unsigned CW  = 4;
  localparam int unsigned AW  = 16;
  localparam int unsigned AWB = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, start, operand_valid, out_ready;
  logic [CW-1:0] length;
  logic [2*WS-1:0] product;
  logic [WS-1:0] op_a, op_b;
  logic [2*WS-1:0] mpipe [LAT];

  logic          operand_ready, busy, out_valid, overflow;
  logic [AW-1:0] out;
  logic          operand_ready_b, busy_b, out_valid_b, overflow_b;
  logic [AWB-1:0] out_b;

  reflet_mult_accumulator #(.WORD_SIZE(WS), .MULT_LATENCY(LAT), .COUNT_WIDTH(CW),
                            .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .length(length),
    .operand_valid(operand_valid), .operand_ready(operand_ready), .product(product),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .overflow(overflow));

  reflet_mult_accumulator #(.WORD_SIZE(WS), .MULT_LATENCY(LAT), .COUNT_WIDTH(CW),
                            .ACC_WIDTH(AWB)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .length(length),
    .operand_valid(operand_valid), .operand_ready(operand_ready_b), .product(product),
    .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b),
    .overflow(overflow_b));

  // Free-running multiplier model, stalled by enable.
  always @(posedge clk) begin
    if (enable) begin
      mpipe[0] <= op_a * op_b;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign product = mpipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned res;
    bit          ovf;
    int unsigned res_b;
    bit          ovf_b;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  bit   presented = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  task automatic push_exp(input int unsigned sum, input int exp_cyc);
    exp_t e;
    e.res   = (sum > 65535) ? 65535 : sum;
    e.ovf   = (sum > 65535);
    e.res_b = (sum > 32767) ? 32767 : sum;
    e.ovf_b = (sum > 32767);
    e.cyc   = exp_cyc;
    sb.push_back(e);
  endtask

  // Monitor: first cycle of a result pops and checks; later cycles check stability.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (!presented) begin
        if (sb.size() == 0) begin
          bound_fail("unexpected_out_valid");
        end else begin
          cur = sb.pop_front();
          chk("out", 32'(out), cur.res);
          chk("overflow", 32'(overflow), 32'(cur.ovf));
          chk("out_w15", 32'(out_b), cur.res_b);
          chk("overflow_w15", 32'(overflow_b), 32'(cur.ovf_b));
          chk("out_valid_cycle", 32'(cyc), 32'(cur.cyc));
          presented = 1'b1;
        end
      end else begin
        chk("out_stable", 32'(out), cur.res);
        chk("overflow_stable", 32'(overflow), 32'(cur.ovf));
      end
      if (out_ready) presented = 1'b0;
    end
  end

  int last_issue;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start  = 1'b1;
    length = CW'(len);
    tick();
    start  = 1'b0;
  endtask

  task automatic issue(input int a, input int b);
    int n = 0;
    operand_valid = 1'b1;
    op_a = WS'(a);
    op_b = WS'(b);
    while (!(operand_ready && enable) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) bound_fail("issue_wait");
    last_issue = cyc;
    tick();
    operand_valid = 1'b0;
    op_a = WS'($urandom_range(1, 63));
    op_b = WS'($urandom_range(1, 63));
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) bound_fail(nm);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, 32'(operand_ready), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_valid"}, 32'(out_valid), 0);
    chk({nm, "_out"}, 32'(out), 0);
    chk({nm, "_overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    int s;
    reset = 1'b0; enable = 1'b1; start = 1'b0; out_ready = 1'b1;
    operand_valid = 1'b0; length = '0;
    op_a = WS'(17); op_b = WS'(29);
    repeat (2) tick();
    chk_all_zero("reset");
    chk("reset_out_w15", 32'(out_b), 0);
    reset = 1'b1;
    tick();

    // 1: three back-to-back terms
    do_start(3);
    issue(1, 10); issue(10, 12); issue(3, 4);
    push_exp(142, last_issue + LAT + 1);
    wait_done("t1_done");

    // 2: zero-length product
    s = cyc;
    push_exp(0, s + 1);
    do_start(0);
    chk("len0_ready_a", 32'(operand_ready), 0);
    tick();
    chk("len0_ready_b", 32'(operand_ready), 0);
    wait_done("t2_done");

    // 3: fifteen max-value terms (saturates only the 15-bit build)
    do_start(15);
    for (int i = 0; i < 15; i++) issue(63, 63);
    push_exp(59535, last_issue + LAT + 1);
    wait_done("t3_done");

    // 4: stalls between issues and during drain, extra operand after the last term
    do_start(2);
    issue(5, 7);
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    issue(9, 11);
    push_exp(134, last_issue + LAT + 1 + 4);
    operand_valid = 1'b1;
    tick();
    chk("extra_op_ready", 32'(operand_ready), 0);
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    operand_valid = 1'b0;
    wait_done("t4_done");

    // 5: consumer back-pressure with start pulses
    do_start(2);
    issue(4, 5); issue(6, 7);
    push_exp(62, last_issue + LAT + 1);
    out_ready = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) bound_fail("t5_valid_wait");
    end
    for (int i = 0; i < 5; i++) begin
      start  = (i % 2 == 0);
      length = CW'(3);
      tick();
    end
    chk("bp_valid_held", 32'(out_valid), 1);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_hs_busy", 32'(busy), 0);
    chk("post_hs_valid", 32'(out_valid), 0);
    tick();
    chk("hs_start_ignored", 32'(busy), 0);

    // 6: abort with tags in flight, then a clean single-term run
    do_start(5);
    issue(7, 9); issue(8, 8); issue(5, 6);
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("abort");
    tick();
    reset = 1'b1;
    tick();
    do_start(1);
    issue(2, 3);
    push_exp(6, last_issue + LAT + 1);
    wait_done("t6_done");
    repeat (LAT + 2) tick();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
